// File: rtl/qarma128_pkg.sv
// Shared types and constants for the QARMA-128 add-round-tweakey + SubCells engine.
// The cell S-box applies the 4-bit substitution below to both nibbles of each 8-bit cell.
package qarma128_pkg;

    localparam int STATE_W = 128;
    localparam int CELL_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    function automatic logic [STATE_W-1:0] rc(input logic [1:0] idx);
        logic [STATE_W-1:0] v;
        case (idx)
            2'd0:    v = 128'h0;
            2'd1:    v = 128'h243F6A8885A308D313198A2E03707344;
            2'd2:    v = 128'hA4093822299F31D0082EFA98EC4E6C89;
            default: v = 128'h452821E638D01377BE5466CF34E90C6C;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/ark_sub_iter_subcells.sv
// SubCells layer: 16 parallel 8-bit cell S-boxes, purely combinational.
// Zero latency; no flow control.
module ark_sub_iter_subcells
    import qarma128_pkg::*;
(
    input  logic [STATE_W-1:0] i_dat,
    output logic [STATE_W-1:0] o_dat
);

    always_comb begin
        o_dat = '0;
        for (int n = 0; n < STATE_W / 4; n++) begin
            o_dat[4*n +: 4] = sbox4(i_dat[4*n +: 4]);
        end
    end

endmodule

// File: rtl/ark_sub_iter.sv
// Iterative ROUNDS x (state ^ key ^ tweak ^ RC[i] -> SubCells) engine, one round per cycle.
// Result held in DONE until out_ready; no new block is taken until the result drains.
module ark_sub_iter
    import qarma128_pkg::*;
#(
    parameter int ROUNDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic [STATE_W-1:0] key_in,
    input  logic [STATE_W-1:0] tweak_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out
);

    localparam logic [1:0] LAST_CNT = 2'(ROUNDS - 1);

    fsm_t               r_fsm;
    logic [1:0]         r_cnt;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] r_key;
    logic [STATE_W-1:0] r_tweak;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [STATE_W-1:0] w_sub_in;
    logic [STATE_W-1:0] w_sub_out;

    // Round 0 is taken straight from the input ports so the accept edge does useful work.
    always_comb begin
        w_sub_in = r_state ^ r_key ^ r_tweak ^ rc(r_cnt);
        if (r_fsm == IDLE) begin
            w_sub_in = state_in ^ key_in ^ tweak_in ^ rc(2'd0);
        end
    end

    ark_sub_iter_subcells u_subcells (
        .i_dat (w_sub_in),
        .o_dat (w_sub_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_cnt       <= 2'd0;
            r_state     <= '0;
            r_key       <= '0;
            r_tweak     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (!r_in_ready) begin
                        r_in_ready <= 1'b1;
                    end else if (in_valid) begin
                        r_state    <= w_sub_out;
                        r_key      <= key_in;
                        r_tweak    <= tweak_in;
                        r_cnt      <= 2'd1;
                        r_in_ready <= 1'b0;
                        if (ROUNDS > 1) begin
                            r_fsm <= RUN;
                        end else begin
                            r_fsm       <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_state <= w_sub_out;
                    // Hold the counter on the last round so it cannot wrap at ROUNDS=4.
                    if (r_cnt == LAST_CNT) begin
                        r_fsm       <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm       <= IDLE;
                        r_cnt       <= 2'd0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign state_out = r_out_valid ? r_state : '0;

endmodule

// File: tb/tb_ark_sub_iter.sv
// Randomized bench for ark_sub_iter (ROUNDS=4 and ROUNDS=1 instances) against a behavioural model.
module tb_ark_sub_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         in_valid, out_ready, in_ready, out_valid;
    logic [127:0] state_in, key_in, tweak_in, state_out;
    logic         b_in_valid, b_out_ready, b_in_ready, b_out_valid;
    logic [127:0] b_state_in, b_key_in, b_tweak_in, b_state_out;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [3:0] M_SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    localparam logic [127:0] M_RC [4] = '{128'h0,
                                          128'h243F6A8885A308D313198A2E03707344,
                                          128'hA4093822299F31D0082EFA98EC4E6C89,
                                          128'h452821E638D01377BE5466CF34E90C6C};

    ark_sub_iter #(.ROUNDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .key_in(key_in), .tweak_in(tweak_in),
        .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out)
    );

    ark_sub_iter #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .state_in(b_state_in), .key_in(b_key_in), .tweak_in(b_tweak_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .state_out(b_state_out)
    );

    function automatic logic [7:0] cell_sbox(input logic [7:0] c);
        logic [3:0] hi, lo;
        hi = M_SBOX[c[7:4]];
        lo = M_SBOX[c[3:0]];
        return {hi, lo};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                           input logic [127:0] t, input int rounds);
        logic [127:0] x;
        x = s;
        for (int r = 0; r < rounds; r++) begin
            x = x ^ k ^ t ^ M_RC[r];
            for (int c = 0; c < 16; c++) x[8*c +: 8] = cell_sbox(x[8*c +: 8]);
        end
        return x;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one block to the ROUNDS=4 instance and waits for out_valid; leaves the result pending.
    task automatic run4(input logic [127:0] s, input logic [127:0] k, input logic [127:0] t,
                        input bit toggle, output logic [127:0] res, output int lat);
        int w;
        state_in = s; key_in = k; tweak_in = t; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        res = '0;
        lat = 0;
        while (!in_ready && w < 20) begin step(); w++; end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (toggle) begin key_in = rnd128(); tweak_in = rnd128(); end
            step();
            lat++;
        end
        res = state_out;
    endtask

    task automatic handshake4();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        step(); step();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (state_out !== 128'h0) begin n_fail++; $display("FAIL reset_state_out got %h want 0", state_out); end
        n_tests++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_in_ready got %b want 0", b_in_ready); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_before_edge got %b want 0", in_ready); end
        step();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_first_edge got %b want 1", in_ready); end
        n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL release_b_first_edge got %b want 1", b_in_ready); end
    endtask

    task automatic test_single_round();
        logic [127:0] exp;
        for (int b = 0; b < 4; b++) begin
            if (b == 0) begin
                b_state_in = '0; b_key_in = '0; b_tweak_in = '0;
                exp = {16{cell_sbox(8'h00)}};
            end else begin
                b_state_in = rnd128(); b_key_in = rnd128(); b_tweak_in = rnd128();
                exp = model(b_state_in, b_key_in, b_tweak_in, 1);
            end
            b_out_ready = 1'b1;
            b_in_valid  = 1'b1;
            for (int w = 0; w < 20 && !b_in_ready; w++) step();
            step();
            b_in_valid = 1'b0;
            n_tests++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL r1_latency blk%0d out_valid got %b want 1", b, b_out_valid); end
            n_tests++; if (b_state_out !== exp) begin n_fail++; $display("FAIL r1_result blk%0d got %h want %h", b, b_state_out, exp); end
            step();
            n_tests++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
                n_fail++; $display("FAIL r1_drain blk%0d out_valid=%b in_ready=%b want 0/1", b, b_out_valid, b_in_ready);
            end
        end
        b_out_ready = 1'b0;
    endtask

    task automatic test_random4();
        logic [127:0] s, k, t, res, exp;
        int lat;
        for (int b = 0; b < 5; b++) begin
            s = rnd128(); k = rnd128(); t = rnd128();
            exp = model(s, k, t, 4);
            run4(s, k, t, 1'b0, res, lat);
            n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL r4_latency blk%0d got %0d want 4", b, lat); end
            n_tests++; if (res !== exp) begin n_fail++; $display("FAIL r4_result blk%0d got %h want %h", b, res, exp); end
            handshake4();
        end
    endtask

    task automatic test_hold();
        logic [127:0] s, k, t, res, exp;
        int lat;
        s = rnd128(); k = rnd128(); t = rnd128();
        exp = model(s, k, t, 4);
        run4(s, k, t, 1'b0, res, lat);
        for (int c = 0; c < 10; c++) begin
            n_tests++; if (out_valid !== 1'b1 || state_out !== exp || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_c%0d out_valid=%b in_ready=%b state_out=%h want 1/0/%h", c, out_valid, in_ready, state_out, exp);
            end
            step();
        end
        handshake4();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        n_tests++; if (state_out !== 128'h0) begin n_fail++; $display("FAIL hold_zero_out got %h want 0", state_out); end
    endtask

    task automatic test_toggle();
        logic [127:0] s, k, t, res, exp;
        int lat;
        for (int b = 0; b < 2; b++) begin
            s = rnd128(); k = rnd128(); t = rnd128();
            exp = model(s, k, t, 4);
            run4(s, k, t, 1'b1, res, lat);
            n_tests++; if (res !== exp) begin n_fail++; $display("FAIL toggle_result blk%0d got %h want %h", b, res, exp); end
            handshake4();
        end
    endtask

    task automatic test_reset_midrun();
        logic [127:0] s, k, t, res, exp;
        int lat;
        state_in = rnd128(); key_in = rnd128(); tweak_in = rnd128();
        in_valid = 1'b1;
        for (int w = 0; w < 20 && !in_ready; w++) step();
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || state_out !== 128'h0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset out_valid=%b in_ready=%b state_out=%h want 0/0/0", out_valid, in_ready, state_out);
        end
        step();
        rst_n = 1'b1;
        step();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrun_recover in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        s = rnd128(); k = rnd128(); t = rnd128();
        exp = model(s, k, t, 4);
        run4(s, k, t, 1'b0, res, lat);
        n_tests++; if (res !== exp || lat !== 4) begin
            n_fail++; $display("FAIL midrun_next got %h lat %0d want %h lat 4", res, lat, exp);
        end
        handshake4();
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q [$];
        logic [127:0] exp;
        int accepts, outs, last_acc, cyc;
        bit acc_now;
        accepts = 0; outs = 0; last_acc = 0; cyc = 0;
        state_in = rnd128(); key_in = rnd128(); tweak_in = rnd128();
        in_valid = 1'b1; out_ready = 1'b1;
        while (cyc < 80 && outs < 3) begin
            acc_now = 1'b0;
            if (in_valid && in_ready) begin
                if (accepts > 0) begin
                    n_tests++; if (cyc - last_acc !== 5) begin
                        n_fail++; $display("FAIL b2b_spacing got %0d want 5", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                exp_q.push_back(model(state_in, key_in, tweak_in, 4));
                accepts++;
                acc_now = 1'b1;
            end
            if (out_valid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                n_tests++; if (state_out !== exp) begin
                    n_fail++; $display("FAIL b2b_result%0d got %h want %h", outs, state_out, exp);
                end
                outs++;
            end
            step();
            cyc++;
            if (acc_now) begin
                if (accepts < 3) begin
                    state_in = rnd128(); key_in = rnd128(); tweak_in = rnd128();
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_tests++; if (accepts !== 3 || outs !== 3) begin
            n_fail++; $display("FAIL b2b_count accepts=%0d outs=%0d want 3/3", accepts, outs);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0;
        state_in = '0; key_in = '0; tweak_in = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_state_in = '0; b_key_in = '0; b_tweak_in = '0;
        test_reset();
        test_single_round();
        test_random4();
        test_hold();
        test_toggle();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
